// File: rtl/reg_writeback_ctrl.sv
// reg_writeback_ctrl: merges ALU and load results through a small FIFO into the register file write port,
// tracking reserved-but-unwritten destinations in a busy scoreboard.
module reg_writeback_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          alu_valid,
  input  logic [ADDR_W-1:0]             alu_addr,
  input  logic [DATA_W-1:0]             alu_data,
  output logic                          alu_ready,
  input  logic                          mem_valid,
  input  logic [ADDR_W-1:0]             mem_addr,
  input  logic [DATA_W-1:0]             mem_data,
  output logic                          mem_ready,
  input  logic                          reserve_valid,
  input  logic [ADDR_W-1:0]             reserve_addr,
  output logic [31:0]                   busy_mask,
  output logic                          reg_write,
  output logic [ADDR_W-1:0]             write_addr,
  output logic [DATA_W-1:0]             write_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = ADDR_W + DATA_W;
  logic [EW-1:0]     buf_q [FIFO_DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic              full, push, pop;
  logic [EW-1:0]     push_entry, head;
  logic [ADDR_W-1:0] head_addr;
  logic [31:0]       busy_next;
  // ready ignores a same-cycle pop, so a full buffer always stalls for one cycle
  assign full       = fifo_count == CW'(FIFO_DEPTH);
  assign mem_ready  = !full;
  assign alu_ready  = !full && !mem_valid;
  assign push       = (mem_valid && mem_ready) || (alu_valid && alu_ready);
  assign push_entry = mem_valid ? {mem_addr, mem_data} : {alu_addr, alu_data};
  assign pop        = fifo_count != '0;
  assign head       = buf_q[rd_ptr];
  assign head_addr  = head[EW-1:DATA_W];
  always_comb begin
    busy_next = busy_mask;
    if (pop && head_addr != '0) busy_next[head_addr] = 1'b0;
    if (reserve_valid && reserve_addr != '0) busy_next[reserve_addr] = 1'b1;
    busy_next[0] = 1'b0;
  end
  always_ff @(posedge clk)
    if (push) buf_q[wr_ptr] <= push_entry;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
      busy_mask  <= '0;
      reg_write  <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
      busy_mask  <= busy_next;
      reg_write  <= pop && head_addr != '0;
      if (pop) begin
        write_addr <= head_addr;
        write_data <= head[DATA_W-1:0];
      end
    end
endmodule
